// File: rtl/pearl_mem_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner tags and
// the byte-enable constant used for fetches.
package pearl_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int unsigned BE_MAX_W = 16;
    localparam logic [BE_MAX_W-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single memory bus port shared by instruction fetch and load/store,
// one transaction at a time, data-first with a bounded fetch starvation.
module mem_port_arbiter
    import pearl_mem_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_ready,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_be,
    output logic              d_ready,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,

    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_be,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_err
);

    localparam int BW = XLEN / 8;
    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);
    localparam logic [BW-1:0] BE_FETCH = BE_ALL_ONES[BW-1:0];

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]     be_q, be_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              kill_q, kill_d;
    logic [3:0]        streak_q, streak_d;

    logic at_max;
    logic grant_d;
    logic grant_if;

    assign at_max   = (streak_q == MAX_STREAK);
    assign grant_d  = d_req && !(if_req && at_max);
    assign grant_if = !grant_d && if_req && !if_kill;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        kill_d   = kill_q;
        streak_d = streak_q;
        unique case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (grant_d) begin
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    be_d    = d_be;
                    state_d = ISSUE;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (!at_max) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (grant_if) begin
                    owner_d  = OWN_IF;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    be_d     = BE_FETCH;
                    streak_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (owner_q == OWN_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                if (bus_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == OWN_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    err_d   = bus_err;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Requests are not sampled here so a still-held req cannot re-issue.
                kill_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            kill_q   <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            kill_q   <= kill_d;
            streak_q <= streak_d;
        end
    end

    assign bus_req   = (state_q == ISSUE);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;

    assign if_ready  = (state_q == DONE) && (owner_q == OWN_IF) && !kill_q;
    assign if_err    = if_ready && err_q;
    assign if_rdata  = rdata_q;

    assign d_ready   = (state_q == DONE) && (owner_q == OWN_D);
    assign d_err     = d_ready && err_q;
    assign d_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: bus slave, requesters and a
// transaction-level reference model of grants, kills and responses.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 32;
    localparam int MAXS = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            if_req = 1'b0, if_kill = 1'b0;
    logic [AW-1:0]   if_addr = '0;
    logic            if_ready, if_err;
    logic [XLEN-1:0] if_rdata;
    logic            d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0]   d_addr = '0;
    logic [XLEN-1:0] d_wdata = '0;
    logic [3:0]      d_be = '0;
    logic            d_ready, d_err;
    logic [XLEN-1:0] d_rdata;
    logic            bus_req, bus_we;
    logic [AW-1:0]   bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [3:0]      bus_be;
    logic            bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
    logic [XLEN-1:0] bus_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(AW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    int total = 0;
    int bad = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0, err_pct = 0;
    bit fix_en = 0;
    logic [XLEN-1:0] fix_data = '0;

    int cyc = 0;
    int ph = 0, prev_ph = 0, ms = 0, g = 0;
    int gwait = 0, rwait = 0;
    bit hs, rv, outst = 0, own_d = 0;
    bit last_req = 0, last_gnt = 0, last_rv = 0, last_we = 0;
    logic [3:0] last_be = '0;
    logic [AW-1:0] last_addr = '0, t_addr = '0;
    logic [XLEN-1:0] r_data = '0;
    logic r_err = 0;
    bit exp_if, exp_d;
    bit issued[logic [AW-1:0]];
    bit killed[logic [AW-1:0]];
    bit if_done = 0, d_done = 0, d_auto = 0;
    int if_cnt = 0, d_cnt = 0, if_rc = 0, d_rc = 0, d_at_if = 0;
    logic [XLEN-1:0] if_last_data = '0;
    logic if_last_err = 0, d_last_err = 0;
    int f_seq = 0, d_seq = 0;

    // Bus slave and scoreboard, sampled 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            bus_gnt = 0; bus_rvalid = 0; outst = 0; ph = 0; ms = 0;
            gwait = 0; last_req = 0; last_gnt = 0; last_rv = 0;
            issued.delete();
            continue;
        end
        hs = last_req && last_gnt;
        rv = last_rv;
        prev_ph = ph;
        if (rv) ph = 2;
        else if (ph == 2) ph = 0;
        if (prev_ph == 0) begin
            g = 0;
            if (d_req && !(if_req && ms == MAXS)) g = 2;
            else if (if_req && !if_kill) g = 1;
            check("grant", bus_req, g != 0);
            if (g == 2) ms = if_req ? ((ms < MAXS) ? ms + 1 : ms) : 0;
            else if (g == 1) ms = 0;
            if (g != 0 && bus_req) begin
                own_d = (g == 2);
                ph = 1;
                t_addr = own_d ? d_addr : if_addr;
                check("issue_addr", bus_addr, t_addr);
                check("issue_we", bus_we, own_d ? d_we : 1'b0);
                check("issue_be", bus_be, own_d ? d_be : 4'hF);
                if (own_d) check("issue_wdata", bus_wdata, d_wdata);
                check("issue_once", issued.exists(t_addr), 0);
                issued[t_addr] = 1;
                gwait = $urandom_range(gnt_max, gnt_min);
            end
        end else if (prev_ph == 1 && last_req && !last_gnt) begin
            check("hold", {bus_req, bus_we, bus_be, bus_addr},
                  {1'b1, last_we, last_be, last_addr});
        end
        if (hs) begin
            check("req_drop", bus_req, 0);
            outst = 1;
            rwait = $urandom_range(rv_max, rv_min);
            r_data = fix_en ? fix_data : $urandom;
            r_err = ($urandom_range(0, 99) < err_pct);
        end
        exp_if = rv && !own_d && !killed.exists(t_addr);
        exp_d = rv && own_d;
        if (if_ready || exp_if) begin
            check("if_ready", if_ready, exp_if);
            if (if_ready) begin
                check("if_rdata", if_rdata, r_data);
                check("if_err", if_err, r_err);
                if_done = 1; if_cnt++; if_rc = cyc; d_at_if = d_cnt;
                if_last_data = if_rdata; if_last_err = if_err;
            end
        end
        if (d_ready || exp_d) begin
            check("d_ready", d_ready, exp_d);
            if (d_ready) begin
                check("d_rdata", d_rdata, r_data);
                check("d_err", d_err, r_err);
                d_done = 1; d_cnt++; d_rc = cyc; d_last_err = d_err;
            end
        end
        bus_gnt = bus_req ? (gwait == 0) : 1'($urandom_range(0, 1));
        if (bus_req && gwait > 0) gwait--;
        bus_rvalid = 0;
        bus_rdata = $urandom;
        bus_err = 1'($urandom_range(0, 1));
        if (outst) begin
            if (rwait == 0) begin
                bus_rvalid = 1; bus_rdata = r_data; bus_err = r_err; outst = 0;
            end else begin
                rwait--;
            end
        end
        last_req = bus_req; last_gnt = bus_gnt; last_rv = bus_rvalid;
        last_we = bus_we; last_be = bus_be; last_addr = bus_addr;
    end

    always @(posedge clk)
        if (rst_n && bus_rvalid) assert (!bus_req) else $error("rvalid during issue");

    task automatic new_d();
        d_seq++;
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'h2000_0000 + 32'(d_seq * 4);
        d_wdata = $urandom; d_be = 4'($urandom_range(1, 15));
    endtask

    function automatic logic [AW-1:0] next_faddr();
        f_seq++;
        return 32'h1000_0000 + 32'(f_seq * 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
        if_kill = 0;
        if (if_done) begin if_done = 0; if_req = 0; end
        if (d_done) begin
            d_done = 0;
            if (d_auto) new_d(); else d_req = 0;
        end
    endtask

    task automatic fetch(logic [AW-1:0] a);
        if_req = 1; if_addr = a;
    endtask

    task automatic dreq(logic we, logic [AW-1:0] a, logic [XLEN-1:0] wd, logic [3:0] be);
        d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    endtask

    task automatic kill(bit refetch, logic [AW-1:0] na);
        killed[if_addr] = 1;
        if_kill = 1;
        if (refetch) if_addr = na; else if_req = 0;
    endtask

    task automatic wait_done(int lim);
        int n = 0;
        while ((if_req || d_req) && n < lim) begin step(); n++; end
        check("timeout", {if_req, d_req}, 0);
    endtask

    int c0, i0, d0;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        fix_en = 1; fix_data = 32'hDEAD_BEEF;
        step(); fetch(32'h100); c0 = cyc;
        wait_done(50);
        check("t1_latency", if_rc - c0, 3);
        check("t1_data", if_last_data, 32'hDEAD_BEEF);
        check("t1_err", if_last_err, 0);

        fix_en = 0;
        step(); i0 = if_cnt; d0 = d_cnt;
        dreq(1, 32'h200, 32'h1234_5678, 4'hF); fetch(32'h104);
        wait_done(50);
        check("t2_order", d_rc < if_rc, 1);
        check("t2_once", (if_cnt - i0) * 16 + (d_cnt - d0), 17);

        step(); d_auto = 1; d0 = d_cnt;
        fetch(32'h108); new_d();
        for (int n = 0; n < 200 && if_req; n++) step();
        check("t3_streak", d_at_if - d0, MAXS);
        d_auto = 0;
        wait_done(50);

        rv_min = 2; rv_max = 2;
        step(); fetch(32'h10C);
        step(); step();
        i0 = if_cnt; kill(0, '0);
        repeat (10) step();
        check("t4_killed", if_cnt - i0, 0);
        rv_min = 0; rv_max = 0;
        fetch(32'h110);
        wait_done(50);
        check("t4_next", if_cnt - i0, 1);

        err_pct = 100; rv_max = 1;
        step(); dreq(0, 32'h400, '0, 4'hF);
        wait_done(50);
        check("t5_err", d_last_err, 1);
        err_pct = 0;
        step(); dreq(0, 32'h404, '0, 4'h3);
        wait_done(50);
        check("t5_clear", d_last_err, 0);

        gnt_min = 1000; gnt_max = 1000;
        step(); fetch(32'h114);
        step(); step();
        check("t6_pre", bus_req, 1);
        #1 rst_n = 0;
        #1;
        check("t6_req", bus_req, 0);
        check("t6_flags", {if_ready, d_ready, if_err, d_err, bus_we, bus_be}, 0);
        check("t6_addr", bus_addr, 0);
        check("t6_rdata", {if_rdata, d_rdata}, 0);
        if_req = 0; d_req = 0; gnt_min = 0; gnt_max = 0;
        step(); step();
        rst_n = 1;
        i0 = if_cnt;
        step(); fetch(32'h118);
        wait_done(50);
        check("t6_after", if_cnt - i0, 1);

        gnt_max = 2; rv_max = 3; err_pct = 25;
        for (int n = 0; n < 1500; n++) begin
            step();
            if (!if_req && $urandom_range(0, 3) == 0) fetch(next_faddr());
            else if (if_req && $urandom_range(0, 29) == 0)
                kill(1'($urandom_range(0, 1)), next_faddr());
            if (!d_req && $urandom_range(0, 2) == 0) new_d();
        end
        wait_done(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
